regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of a per-thread register file between NUM_REQ

---
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request bus shared by the requesters and the arbiter
// Per-requester valid/ready handshake with packed address and data lanes;
// requester i occupies [i*ADDR_W +: ADDR_W] and [i*DATA_W +: DATA_W].
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  // Write-back sources: present requests, observe the grant.
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // Arbiter: observes requests, issues the one-hot grant.
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the register-file write port with busy scoreboard
// NUM_REQ write-back sources compete for one registered write port. The
// winner is the first valid requester scanning from rr_ptr upward (wrapping).
// Writes to addresses >= NUM_GPR are accepted but dropped and flagged.
// A per-GPR busy bit is set by issue and cleared when the write registers;
// when both hit the same register on one edge the set wins, because it
// represents a newer producer still in flight.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NUM_GPR = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  regfile_wb_arbiter_if.slave      req_bus,
  input  logic                     sb_set_valid,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic [NUM_GPR-1:0]       sb_busy,
  output logic                     rf_write_enable,
  output logic [ADDR_W-1:0]        rf_write_addr,
  output logic [DATA_W-1:0]        rf_write_data,
  output logic                     ro_violation,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ro_violation_id
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] grant;
  logic               arb_active;
  logic               transfer;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic               win_writable;
  logic [NUM_GPR-1:0] busy_next;

  // Index k positions after base, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Addresses below NUM_GPR are architectural GPRs; the rest are read-only.
  function automatic logic is_writable(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_GPR);
  endfunction

  // No grants while disabled or while reset is held.
  assign arb_active = en & ~reset;

  // Round-robin scan from rr_ptr; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_bus.req_valid[rot_idx(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = rot_idx(rr_ptr, k);
      end
    end
    if (arb_active && win_found) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign req_bus.req_ready = grant;

  // The grant only ever lands on a valid requester, so a grant is a transfer.
  assign transfer = |grant;

  // Select the granted requester's address and data lanes.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = req_bus.req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign win_writable = is_writable(win_addr);

  // Pointer moves to the slot after the winner so it has lowest priority next.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (transfer) begin
      if (win_idx == PTR_W'(NUM_REQ - 1)) rr_ptr_next = '0;
      else                                rr_ptr_next = win_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register; frozen whenever nothing transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_ptr_next;
  end

  // Registered write stage: one-cycle strobe, address/data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= transfer && win_writable;
      if (transfer && win_writable) begin
        rf_write_addr <= win_addr;
        rf_write_data <= win_data;
      end
    end
  end

  // Read-only target: pulse the violation flag and remember who caused it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ro_violation    <= 1'b0;
      ro_violation_id <= '0;
    end else begin
      ro_violation <= transfer && !win_writable;
      if (transfer && !win_writable) begin
        ro_violation_id <= win_idx;
      end
    end
  end

  // Busy next-state: clear on a registered write, then apply issue so set wins.
  always_comb begin
    busy_next = sb_busy;
    for (int r = 0; r < NUM_GPR; r++) begin
      if (transfer && win_writable && win_addr == ADDR_W'(r)) begin
        busy_next[r] = 1'b0;
      end
    end
    for (int r = 0; r < NUM_GPR; r++) begin
      if (sb_set_valid && sb_set_addr == ADDR_W'(r)) begin
        busy_next[r] = 1'b1;
      end
    end
  end

  // Busy scoreboard register; issue is honoured whether or not arbitration is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb_busy <= '0;
    else       sb_busy <= busy_next;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int NUM_GPR = 13;

  typedef struct {
    bit              ro;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int              id;
    int              due;
  } ev_t;

  typedef struct {
    logic [NUM_GPR-1:0] busy;
    int                 due;
  } bz_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b0;
  logic               sb_set_valid = 1'b0;
  logic [ADDR_W-1:0]  sb_set_addr = '0;
  logic [NUM_GPR-1:0] sb_busy;
  logic               rf_write_enable;
  logic [ADDR_W-1:0]  rf_write_addr;
  logic [DATA_W-1:0]  rf_write_data;
  logic               ro_violation;
  logic [1:0]         ro_violation_id;

  regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_GPR(NUM_GPR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .req_bus         (bus),
    .sb_set_valid    (sb_set_valid),
    .sb_set_addr     (sb_set_addr),
    .sb_busy         (sb_busy),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .ro_violation    (ro_violation),
    .ro_violation_id (ro_violation_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  ev_t ev_q[$];
  bz_t bz_q[$];
  bit  mon_en = 1'b0;

  // Requester state and stimulus shadows, applied to the DUT inside step().
  bit                pend_v [NUM_REQ];
  logic [ADDR_W-1:0] pend_a [NUM_REQ];
  logic [DATA_W-1:0] pend_d [NUM_REQ];
  bit                en_s = 1'b0;
  bit                sbv_s = 1'b0;
  logic [ADDR_W-1:0] sba_s = '0;
  int                mode = 0;

  // Reference model state.
  int                 rr_m = 0;
  logic [NUM_GPR-1:0] busy_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_req(input int i);
    pend_a[i] = 4'($urandom_range(0, 15));
    pend_d[i] = 8'($urandom_range(0, 255));
  endtask

  // One clock of stimulus: drive, predict, check the grant, queue expectations.
  task automatic step();
    int win;
    int j;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_GPR-1:0] nb;
    ev_t e;
    bz_t b;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = pend_v[i];
      bus.req_addr[i*ADDR_W +: ADDR_W] = pend_a[i];
      bus.req_data[i*DATA_W +: DATA_W] = pend_d[i];
    end
    en = en_s;
    sb_set_valid = sbv_s;
    sb_set_addr = sba_s;
    #1;
    win = -1;
    if (en_s) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (rr_m + k) % NUM_REQ;
        if (win < 0 && pend_v[j]) win = j;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    nb = busy_m;
    if (win >= 0) begin
      e.ro = (int'(pend_a[win]) >= NUM_GPR);
      e.addr = pend_a[win];
      e.data = pend_d[win];
      e.id = win;
      e.due = cyc + 1;
      ev_q.push_back(e);
      if (!e.ro) nb[pend_a[win]] = 1'b0;
      rr_m = (win + 1) % NUM_REQ;
      case (mode)
        0: pend_v[win] = 1'b0;
        1: new_req(win);
        default: begin
          pend_v[win] = 1'($urandom_range(0, 1));
          new_req(win);
        end
      endcase
    end
    if (sbv_s && int'(sba_s) < NUM_GPR) nb[sba_s] = 1'b1;
    busy_m = nb;
    b.busy = nb;
    b.due = cyc + 1;
    bz_q.push_back(b);
  endtask

  // Monitor: pops expectations whenever the registered outputs present a result.
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  initial begin
    ev_t e;
    bz_t b;
    last_addr = '0;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        last_addr = '0;
        last_data = '0;
      end else begin
        while (ev_q.size() > 0 && ev_q[0].due < cyc) begin
          e = ev_q.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_output: no result for requester %0d addr %0h (due cycle %0d)", e.id, e.addr, e.due);
        end
        if (rf_write_enable || ro_violation) begin
          if (ev_q.size() == 0 || ev_q[0].due != cyc) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: we=%0b ro=%0b with nothing expected (cycle %0d)", rf_write_enable, ro_violation, cyc);
          end else begin
            e = ev_q.pop_front();
            check("rf_write_enable", 32'(rf_write_enable), 32'(!e.ro));
            check("ro_violation", 32'(ro_violation), 32'(e.ro));
            if (!e.ro) begin
              check("rf_write_addr", 32'(rf_write_addr), 32'(e.addr));
              check("rf_write_data", 32'(rf_write_data), 32'(e.data));
              last_addr = e.addr;
              last_data = e.data;
            end else begin
              check("ro_violation_id", 32'(ro_violation_id), 32'(e.id));
            end
          end
        end else begin
          check("rf_addr_hold", 32'(rf_write_addr), 32'(last_addr));
          check("rf_data_hold", 32'(rf_write_data), 32'(last_data));
        end
        if (bz_q.size() > 0 && bz_q[0].due == cyc) begin
          b = bz_q.pop_front();
          check("sb_busy", 32'(sb_busy), 32'(b.busy));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_d[i] = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
    sbv_s = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  // Assert reset mid-cycle just after a write was registered, then release cleanly.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_rf_write_enable", 32'(rf_write_enable), 32'd0);
    check("rst_sb_busy", 32'(sb_busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_ro_violation", 32'(ro_violation), 32'd0);
    @(negedge clk);
    #2;
    bus.req_valid = '0;
    sb_set_valid = 1'b0;
    reset = 1'b0;
    ev_q.delete();
    bz_q.delete();
    rr_m = 0;
    busy_m = '0;
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_d[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;

    // Reset state, including no grant while reset is held.
    @(negedge clk);
    bus.req_valid = '1;
    en = 1'b1;
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rf_write_enable", 32'(rf_write_enable), 32'd0);
    check("reset_rf_write_addr", 32'(rf_write_addr), 32'd0);
    check("reset_rf_write_data", 32'(rf_write_data), 32'd0);
    check("reset_ro_violation", 32'(ro_violation), 32'd0);
    check("reset_ro_violation_id", 32'(ro_violation_id), 32'd0);
    check("reset_sb_busy", 32'(sb_busy), 32'd0);
    @(negedge clk);
    #2;
    bus.req_valid = '0;
    en = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;

    // Contention: all valid and re-presenting after accept.
    en_s = 1'b1;
    mode = 1;
    set_req(0, 4'd1, 8'h10);
    set_req(1, 4'd2, 8'h20);
    set_req(2, 4'd4, 8'h40);
    for (int c = 0; c < 4; c++) step();
    idle(1);

    // Single request.
    mode = 0;
    set_req(0, 4'd5, 8'hA5);
    step();
    idle(2);

    // Read-only target.
    set_req(1, 4'd14, 8'h33);
    step();
    idle(2);

    // Scoreboard set, set-over-clear, later clear, ignored read-only set.
    sbv_s = 1'b1; sba_s = 4'd3;
    step();
    sbv_s = 1'b0;
    step();
    set_req(0, 4'd3, 8'h11);
    sbv_s = 1'b1; sba_s = 4'd3;
    step();
    sbv_s = 1'b0;
    step();
    set_req(0, 4'd3, 8'h22);
    sbv_s = 1'b1; sba_s = 4'd7;
    step();
    sbv_s = 1'b1; sba_s = 4'd13;
    step();
    idle(2);

    // Disabled arbitration with all requesters waiting, then resume.
    mode = 1;
    en_s = 1'b0;
    set_req(0, 4'd8, 8'h80);
    set_req(1, 4'd9, 8'h90);
    set_req(2, 4'd15, 8'hF0);
    sbv_s = 1'b1; sba_s = 4'd9;
    step();
    sbv_s = 1'b0;
    for (int c = 0; c < 3; c++) step();
    en_s = 1'b1;
    for (int c = 0; c < 4; c++) step();
    mode = 0;
    idle(2);

    // Randomized traffic.
    mode = 2;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          pend_v[i] = 1'b1;
          new_req(i);
        end
      end
      en_s = ($urandom_range(0, 9) != 0);
      sbv_s = ($urandom_range(0, 2) == 0);
      sba_s = 4'($urandom_range(0, 15));
      step();
    end
    mode = 0;
    en_s = 1'b1;
    idle(2);

    // Reset one cycle after a transfer, then lowest valid index wins.
    set_req(2, 4'd6, 8'h66);
    sbv_s = 1'b1; sba_s = 4'd2;
    step();
    sbv_s = 1'b0;
    mid_reset();
    set_req(1, 4'd10, 8'hAA);
    set_req(2, 4'd11, 8'hBB);
    step();
    idle(4);

    check("scoreboard_drained", 32'(ev_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
